// File: rtl/banco_fifo_salida_pkg.sv
// rtl/banco_fifo_salida_pkg.sv - shared channel count, default sizing and clog2 helper
package banco_fifo_salida_pkg;
  localparam int NUM_CH        = 4;
  localparam int DATA_W_DEF    = 10;
  localparam int DEPTH_DEF     = 8;
  localparam int AF_THRESH_DEF = 6;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/banco_fifo_salida_fifo_canal.sv
// rtl/banco_fifo_salida_fifo_canal.sv - single output channel FIFO with registered read port
// Optional count_out port under BANCO_FIFO_COUNT_EN.
module fifo_canal
  import banco_fifo_salida_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              empty,
  output logic              almost_full,
  output logic              full,
  output logic              overflow,
  output logic              underflow
`ifdef BANCO_FIFO_COUNT_EN
  , output logic [clog2(DEPTH):0] count_out
`endif
);
  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push_acc;
  logic              pop_acc;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AF_THRESH));

  assign pop_acc  = pop & ~empty;
  // A full channel still takes the word when the same edge frees a slot.
  assign push_acc = push & (~full | pop_acc);
  assign overflow  = push & ~push_acc;
  assign underflow = pop & empty;

`ifdef BANCO_FIFO_COUNT_EN
  assign count_out = count;
`endif

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= pop_acc;
      if (pop_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
      end
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (push_acc && !pop_acc)      count <= count + CW'(1);
      else if (pop_acc && !push_acc) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/banco_fifo_salida.sv
// rtl/banco_fifo_salida.sv - bank of four output FIFOs fed by the arbiter push interface
// Optional per-channel count_out port under BANCO_FIFO_COUNT_EN.
module banco_fifo_salida
  import banco_fifo_salida_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        push,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [NUM_CH-1:0]        pop,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        valid_out,
  output logic [NUM_CH-1:0]        emptyFIFO,
  output logic [NUM_CH-1:0]        almost_fullFIFO,
  output logic [NUM_CH-1:0]        full,
  output logic                     err_onehot,
  output logic                     err_overflow,
  output logic                     err_underflow
`ifdef BANCO_FIFO_COUNT_EN
  , output logic [NUM_CH*(clog2(DEPTH)+1)-1:0] count_out
`endif
);
  logic              multi_hot;
  logic [NUM_CH-1:0] push_g;
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] udf;

  // Clearing the lowest set bit leaves something only when more than one bit is set.
  assign multi_hot = ((push & (push - NUM_CH'(1))) != '0);
  assign push_g    = multi_hot ? '0 : push;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_canal
    fifo_canal #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH)
    ) u_canal (
      .clk         (clk),
      .reset       (reset),
      .push        (push_g[i]),
      .pop         (pop[i]),
      .data_in     (data_in),
      .data_out    (data_out[i*DATA_W +: DATA_W]),
      .valid_out   (valid_out[i]),
      .empty       (emptyFIFO[i]),
      .almost_full (almost_fullFIFO[i]),
      .full        (full[i]),
      .overflow    (ovf[i]),
      .underflow   (udf[i])
`ifdef BANCO_FIFO_COUNT_EN
      , .count_out (count_out[i*(clog2(DEPTH)+1) +: clog2(DEPTH)+1])
`endif
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_onehot    <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_onehot    <= multi_hot;
      err_overflow  <= |ovf;
      err_underflow <= |udf;
    end
  end
endmodule

// File: tb/tb_banco_fifo_salida.sv
// tb/tb_banco_fifo_salida.sv - queue-model bench for the output FIFO bank
`timescale 1ns/1ps
module tb_banco_fifo_salida;
  import banco_fifo_salida_pkg::*;
  localparam int W  = DATA_W_DEF;
  localparam int D  = DEPTH_DEF;
  localparam int AF = AF_THRESH_DEF;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   push;
  logic [3:0]   pop;
  logic [W-1:0] data_in;
  logic [4*W-1:0] data_out;
  logic [3:0]   valid_out;
  logic [3:0]   emptyFIFO;
  logic [3:0]   almost_fullFIFO;
  logic [3:0]   full;
  logic         err_onehot;
  logic         err_overflow;
  logic         err_underflow;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [W-1:0] mq [4][$];
  logic [W-1:0] m_lane [4];
  logic [3:0]   m_valid;
  logic         m_oh, m_ov, m_un;

  always #5 clk = ~clk;

  banco_fifo_salida dut (
    .clk             (clk),
    .reset           (reset),
    .push            (push),
    .data_in         (data_in),
    .pop             (pop),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .emptyFIFO       (emptyFIFO),
    .almost_fullFIFO (almost_fullFIFO),
    .full            (full),
    .err_onehot      (err_onehot),
    .err_overflow    (err_overflow),
    .err_underflow   (err_underflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int ch = 0; ch < 4; ch++) begin
      mq[ch].delete();
      m_lane[ch] = '0;
    end
    m_valid = '0;
    m_oh = 1'b0;
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  // Applies the inputs the DUT just sampled at the last posedge.
  task automatic model_apply();
    bit multi, pop_ok, push_ok;
    if (!reset) begin
      model_clear();
      return;
    end
    multi = ($countones(push) > 1);
    m_oh = multi;
    m_ov = 1'b0;
    m_un = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      pop_ok  = pop[ch] && (mq[ch].size() > 0);
      push_ok = !multi && push[ch] && ((mq[ch].size() < D) || pop_ok);
      m_valid[ch] = pop_ok;
      if (pop[ch] && !pop_ok) m_un = 1'b1;
      if (!multi && push[ch] && !push_ok) m_ov = 1'b1;
      if (pop_ok) m_lane[ch] = mq[ch].pop_front();
      if (push_ok) mq[ch].push_back(data_in);
    end
  endtask

  task automatic cyc(input logic [3:0] p, input logic [3:0] q, input logic [W-1:0] d);
    push = p;
    pop = q;
    data_in = d;
    @(posedge clk);
    #1;
    model_apply();
  endtask

  always @(negedge clk) begin : compare
    logic [4*W-1:0] e_do;
    logic [3:0] e_emp, e_af, e_full;
    if (chk_en) begin
      for (int ch = 0; ch < 4; ch++) begin
        e_do[ch*W +: W] = m_lane[ch];
        e_emp[ch]  = (mq[ch].size() == 0);
        e_af[ch]   = (mq[ch].size() >= AF);
        e_full[ch] = (mq[ch].size() == D);
      end
      chk("data_out", 64'(data_out), 64'(e_do));
      chk("valid_out", 64'(valid_out), 64'(m_valid));
      chk("emptyFIFO", 64'(emptyFIFO), 64'(e_emp));
      chk("almost_fullFIFO", 64'(almost_fullFIFO), 64'(e_af));
      chk("full", 64'(full), 64'(e_full));
      chk("err_onehot", 64'(err_onehot), 64'(m_oh));
      chk("err_overflow", 64'(err_overflow), 64'(m_ov));
      chk("err_underflow", 64'(err_underflow), 64'(m_un));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [3:0] p, q;
    int ov_seen;
    reset = 1'b0;
    push = '0;
    pop = '0;
    data_in = '0;
    model_clear();
    cyc(4'h0, 4'h0, '0);
    cyc(4'h0, 4'h0, '0);
    chk("rst_empty", 64'(emptyFIFO), 64'hF);
    chk("rst_af", 64'(almost_fullFIFO), 64'h0);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_valid", 64'(valid_out), 64'h0);
    chk("rst_dout", 64'(data_out), 64'h0);
    chk_en = 1'b1;
    reset = 1'b1;

    // Fill channel 3 and overflow it.
    for (int k = 1; k <= 8; k++) begin
      cyc(4'h8, 4'h0, W'(k));
      if (k == 5) chk("af_after5", 64'(almost_fullFIFO), 64'h0);
      if (k == 6) chk("af_after6", 64'(almost_fullFIFO), 64'h8);
      if (k == 7) chk("full_after7", 64'(full), 64'h0);
      if (k == 8) chk("full_after8", 64'(full), 64'h8);
    end
    cyc(4'h8, 4'h0, W'(9));
    chk("ovf_pulse", 64'(err_overflow), 64'h1);
    cyc(4'h0, 4'h0, '0);
    chk("ovf_clear", 64'(err_overflow), 64'h0);
    chk("full_kept", 64'(full), 64'h8);

    // Ordering and pointer wrap.
    for (int k = 1; k <= 8; k++) begin
      cyc(4'h0, 4'h8, '0);
      chk("ord_lane3", 64'(data_out[3*W +: W]), 64'(k));
      chk("ord_valid3", 64'(valid_out[3]), 64'h1);
    end
    cyc(4'h0, 4'h0, '0);
    chk("idle_valid", 64'(valid_out), 64'h0);
    chk("idle_hold3", 64'(data_out[3*W +: W]), 64'h8);
    for (int k = 10; k <= 13; k++) cyc(4'h8, 4'h0, W'(k));
    for (int k = 0; k < 4; k++) begin
      cyc(4'h0, 4'h8, '0);
      chk("wrap_lane3", 64'(data_out[3*W +: W]), 64'(10 + k));
    end
    cyc(4'h0, 4'h0, '0);
    chk("wrap_empty3", 64'(emptyFIFO[3]), 64'h1);

    // Simultaneous push and pop cases.
    cyc(4'h1, 4'h0, W'('h21));
    cyc(4'h1, 4'h0, W'('h22));
    cyc(4'h1, 4'h1, W'('h23));
    chk("sim0_lane0", 64'(data_out[W-1:0]), 64'h21);
    chk("sim0_valid0", 64'(valid_out[0]), 64'h1);
    for (int k = 0; k < 8; k++) cyc(4'h2, 4'h0, W'('h40 + k));
    cyc(4'h2, 4'h2, W'('h50));
    chk("simfull_noovf", 64'(err_overflow), 64'h0);
    chk("simfull_full1", 64'(full[1]), 64'h1);
    chk("simfull_lane1", 64'(data_out[W +: W]), 64'h40);
    cyc(4'h0, 4'h1, '0);
    cyc(4'h0, 4'h1, '0);
    cyc(4'h1, 4'h1, W'('h2A));
    chk("simempty_udf", 64'(err_underflow), 64'h1);
    chk("simempty_valid0", 64'(valid_out[0]), 64'h0);
    chk("simempty_empty0", 64'(emptyFIFO[0]), 64'h0);

    // Multi-hot push on two empty channels.
    cyc(4'h0, 4'h1, '0);
    for (int k = 0; k < 8; k++) cyc(4'h0, 4'h2, '0);
    cyc(4'h3, 4'h0, W'('h155));
    chk("onehot_pulse", 64'(err_onehot), 64'h1);
    chk("onehot_empty10", 64'(emptyFIFO[1:0]), 64'h3);
    cyc(4'h0, 4'h0, '0);
    chk("onehot_clear", 64'(err_onehot), 64'h0);

    // Random traffic: a filling phase then a draining phase.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 8) p = 4'(1 << $urandom_range(0, 3));
      else if (r < 9) p = 4'h0;
      else p = 4'($urandom_range(0, 15));
      for (int ch = 0; ch < 4; ch++)
        q[ch] = ($urandom_range(0, 9) < ((n < 200) ? 1 : 5));
      cyc(p, q, W'($urandom));
    end

    // Asynchronous reset with channel 2 holding data.
    for (int k = 0; k < D; k++) cyc(4'h0, 4'hF, '0);
    cyc(4'h4, 4'h0, W'(1));
    cyc(4'h4, 4'h0, W'(2));
    cyc(4'h4, 4'h0, W'(3));
    cyc(4'h0, 4'h0, '0);
    chk("pre_rst_empty2", 64'(emptyFIFO[2]), 64'h0);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    chk("async_rst_empty2", 64'(emptyFIFO[2]), 64'h1);
    chk("async_rst_empty", 64'(emptyFIFO), 64'hF);
    cyc(4'h0, 4'h0, '0);
    reset = 1'b1;
    cyc(4'h4, 4'h0, W'('h3F));
    chk("post_rst_push", 64'(emptyFIFO[2]), 64'h0);
    cyc(4'h0, 4'h4, '0);
    chk("post_rst_lane2", 64'(data_out[2*W +: W]), 64'h3F);

    // Simple priority arbiter that honours almost_full.
    ov_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (!almost_fullFIFO[3]) p = 4'h8;
      else if (!almost_fullFIFO[2]) p = 4'h4;
      else if (!almost_fullFIFO[1]) p = 4'h2;
      else p = 4'h0;
      if (i == 6) begin
        chk("arb_af6", 64'(almost_fullFIFO), 64'h8);
        chk("arb_push6", 64'(p), 64'h4);
      end
      if (i == 12) begin
        chk("arb_af12", 64'(almost_fullFIFO), 64'hC);
        chk("arb_push12", 64'(p), 64'h2);
      end
      if (i == 18) begin
        chk("arb_af18", 64'(almost_fullFIFO), 64'hE);
        chk("arb_push18", 64'(p), 64'h0);
      end
      cyc(p, 4'h0, W'($urandom));
      if (err_overflow) ov_seen++;
    end
    chk("arb_no_overflow", 64'(ov_seen), 64'h0);

    cyc(4'h0, 4'h0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/banco_fifo_salida.md
Name: banco_fifo_salida

Overview:
- Bank of 4 independent output FIFOs, one per destination. It is the receiving end of the arbiter's push[3:0] interface.
- It stores the word written by the arbiter into the selected channel.
- It returns the back-pressure flags almost_fullFIFO[3:0] and emptyFIFO[3:0], which the arbiter and downstream logic consume.
- Downstream readers drain each channel independently with pop[3:0].

Parameters:
- DATA_W, 10, word width.
- DEPTH, 8, entries per channel; must be a power of 2, minimum 4.
- AF_THRESH, 6, almost_fullFIFO[i]=1 when count_i >= AF_THRESH. Legal range 1..DEPTH.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- push  in  4  write strobe from the arbiter, one bit per channel; one-hot or zero.
- data_in  in  DATA_W  word written with push.
- pop  in  4  per-channel read strobe from downstream.
- data_out  out  4*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- valid_out  out  4  valid_out[i]=1 the cycle after an accepted pop on channel i.
- emptyFIFO  out  4  channel holds 0 entries.
- almost_fullFIFO  out  4  channel count >= AF_THRESH.
- full  out  4  channel count == DEPTH.
- err_onehot  out  1  one-cycle pulse: push had more than one bit set.
- err_overflow  out  1  one-cycle pulse: push to a full channel was dropped.
- err_underflow  out  1  one-cycle pulse: pop from an empty channel was ignored.

Behaviour:
- Reset, asynchronous, while reset=0:
  - all pointers and counts = 0;
  - data_out = 0, valid_out = 0;
  - emptyFIFO = 4'b1111, almost_fullFIFO = 0, full = 0;
  - all err_* = 0.
  - Reset asserted mid-operation discards all stored data. The first push is accepted on the first posedge with reset=1.
- Storage per channel: circular buffer with wr_ptr and rd_ptr of log2(DEPTH) bits, both wrapping DEPTH-1 -> 0, plus count of log2(DEPTH)+1 bits.
- Flags:
  - decoded combinationally from the registered count only;
  - no path from push/pop to the flags;
  - a flag reflects an event on the cycle after the event's posedge.
- Push, per channel i:
  - condition: push[i]=1, push is one-hot, full[i]=0;
  - effect at posedge: mem[wr_ptr]<=data_in, wr_ptr++, count++.
- Push to a full channel without a same-cycle pop:
  - the word is dropped and err_overflow pulses;
  - the channel state is unchanged.
- Multi-hot push, e.g. 4'b0101:
  - no channel is written;
  - err_onehot pulses, even if some targets are full;
  - pops still proceed normally.
- Pop, per channel i:
  - condition: pop[i]=1 and emptyFIFO[i]=0;
  - effect at posedge: data_out lane i <= mem[rd_ptr], valid_out[i]<=1, rd_ptr++, count--.
  - Latency is 1 cycle from pop to data.
  - valid_out[i]=0 in any cycle without an accepted pop; the data_out lane holds its last value.
- Pop on an empty channel: ignored, err_underflow pulses, valid_out[i]=0. There is no write-to-read bypass.
- Simultaneous push and pop on the same channel:
  - nonempty and not full: both occur, count unchanged.
  - full: both occur, count stays DEPTH, no overflow.
  - empty: the push is accepted, the pop is rejected with err_underflow, count becomes 1.
- err_* outputs are registered, one cycle after the offending posedge, and OR-reduced across channels.
- Channels are fully independent apart from the shared data_in.

Optional Feature:
- Macro: BANCO_FIFO_COUNT_EN.
- When defined:
  - adds output port count_out, width 4*(log2(DEPTH)+1);
  - lane i exposes channel i's registered count;
  - reset value 0.
- When undefined: the port does not exist. All other behaviour is identical.

Decomposition:
- Shared include file, used by the arbiter, this block and the bench:
  - NUM_CH=4;
  - default DATA_W/DEPTH/AF_THRESH;
  - a clog2 function for pointer widths.
- Sub-module fifo_canal, instantiated 4x via generate:
  - single-channel FIFO with push, pop, data_in;
  - outputs data_out, valid_out, empty, almost_full, full, overflow, underflow.
- The top level holds the one-hot check, push gating and err_* reduction/registration.

Test Plan:
- Reset state: reset=0 for 2 cycles, then release.
  - Required: emptyFIFO=4'b1111, almost_fullFIFO=0, full=0, valid_out=0, data_out=0.
  - Assert reset=0 mid-test with channel 2 holding 3 words: emptyFIFO[2] returns to 1 immediately, without waiting for clk.
- Fill and flags, channel 3: push=4'b1000 with data 1..8 over 8 cycles.
  - almost_fullFIFO=4'b1000 after the 6th push.
  - full[3]=1 after the 8th push.
  - A 9th push (data 9) gives err_overflow=1 for one cycle and count stays 8.
- Ordering and wrap: on channel 3, pop 8 times, then push 10..13, then pop 4.
  - data_out[39:30] = 1..8, then 10..13.
  - valid_out[3]=1 exactly one cycle after each pop.
  - emptyFIFO[3]=1 at the end.
- Simultaneous events:
  - Channel 0 holding 2 words, push+pop in the same cycle: count stays 2, oldest word out.
  - Channel 1 full, push+pop: no err_overflow, stays full.
  - Channel 0 empty, push+pop: err_underflow=1, emptyFIFO[0]=0 next cycle.
- Multi-hot push: push=4'b0011, data 0x155.
  - err_onehot=1 for one cycle.
  - emptyFIFO[1:0] unchanged at 2'b11.
- Arbiter interaction: the arbiter sees almost_fullFIFO=4'b1000, then 4'b1100, then 4'b1110.
  - The bench checks the arbiter's push bits 3, 2, 1 deassert in turn.
  - No err_overflow occurs over 30 cycles.
